// File: rtl/alu_pkg.sv
// Shared constants, opcode map and controller state encoding for the 16-bit ALU issue path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W_DEF = 16;

    // ALU operation select driven on alu_op
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Instruction opcodes, instr[15:13]
    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_SUB  = 3'b001;
    localparam logic [2:0] OPC_AND  = 3'b010;
    localparam logic [2:0] OPC_OR   = 3'b011;
    localparam logic [2:0] OPC_ADDI = 3'b100;
    localparam logic [2:0] OPC_BZ   = 3'b101;
    localparam logic [2:0] OPC_BN   = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Instruction field positions (3-bit fields given by their LSB)
    localparam int OPC_LSB = 13;
    localparam int RD_LSB  = 10;
    localparam int RS_LSB  = 7;
    localparam int RT_LSB  = 4;
    localparam int IMM7_W  = 7;
    localparam int IMM10_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB,
        ST_BRANCH,
        ST_HALT
    } state_t;

    // ALU-class opcode to ALU operation; ADDI reuses the adder
    function automatic logic [1:0] opc_to_aluop(input logic [2:0] opc);
        logic [1:0] op;
        case (opc)
            OPC_SUB: op = ALU_SUB;
            OPC_AND: op = ALU_AND;
            OPC_OR:  op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile_r0z.sv
// Register file, NREGS x DATA_W, register 0 reads as zero and ignores writes.
// Latency: reads combinational, write visible the cycle after we is sampled.
// Backpressure: none; always accepts a write.
module regfile_r0z
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [NREGS];

    // Storage: cleared by reset, single write port, writes to r0 dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller: decodes a word, drives the ALU, writes back, resolves Z/N branches. ALU_CTRL_OVF_TRAP_EN adds a sticky ovf output and halts on signed overflow.
// Latency: ALU op accepted in T -> operands in T+1, write in T+2, ready at T+3; branch ready at T+2.
// Backpressure: instr_ready only in IDLE; a word held valid elsewhere waits and is not consumed.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`ifdef ALU_CTRL_OVF_TRAP_EN
    ,output logic             ovf
`endif
);

    state_t            state, state_nxt;
    logic [15:0]       instr_q;
    logic [2:0]        opc_in, opc_q, rs_in, rt_in, rd_q;
    logic [DATA_W-1:0] rs_data, rt_data, imm7_ext;
    logic [PC_W-1:0]   pc_inc, br_off;
    logic              rf_we, zf, nf, accept, is_alu_in, br_taken;

    assign opc_in    = instr[OPC_LSB +: 3];
    assign rs_in     = instr[RS_LSB +: 3];
    assign rt_in     = instr[RT_LSB +: 3];
    assign opc_q     = instr_q[OPC_LSB +: 3];
    assign rd_q      = instr_q[RD_LSB +: 3];
    assign imm7_ext  = DATA_W'($signed(instr[IMM7_W-1:0]));
    assign br_off    = PC_W'($signed(instr_q[IMM10_W-1:0]));
    assign pc_inc    = pc + PC_W'(1);
    assign accept    = instr_valid & instr_ready;
    assign is_alu_in = ~opc_in[2] | (opc_in == OPC_ADDI);
    assign br_taken  = (opc_q == OPC_BZ) ? zf : nf;
    assign halted    = (state == ST_HALT);

    // Operands are read from the incoming word so they are on the bus in EXEC
    regfile_r0z #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (rs_in),
        .ra_data  (rs_data),
        .rb_addr  (rt_in),
        .rb_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (alu_result)
    );

`ifdef ALU_CTRL_OVF_TRAP_EN
    logic is_arith, a_s, b_s, r_s, ovf_now;
    assign is_arith = (opc_q == OPC_ADD) | (opc_q == OPC_SUB) | (opc_q == OPC_ADDI);
    assign a_s      = alu_a[DATA_W-1];
    assign b_s      = alu_b[DATA_W-1] ^ (opc_q == OPC_SUB);
    assign r_s      = alu_result[DATA_W-1];
    assign ovf_now  = (state == ST_WB) && is_arith && (a_s == b_s) && (r_s != a_s);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake and writeback enable
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    if (is_alu_in) begin
                        state_nxt = ST_EXEC;
                    end else if (opc_in == OPC_HALT) begin
                        state_nxt = ST_HALT;
                    end else begin
                        state_nxt = ST_BRANCH;
                    end
                end
            end
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB: begin
                rf_we     = 1'b1;
                state_nxt = ST_IDLE;
`ifdef ALU_CTRL_OVF_TRAP_EN
                if (ovf_now) begin
                    state_nxt = ST_HALT;
                end
`endif
            end
            ST_BRANCH: state_nxt = ST_IDLE;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: word latch, ALU operand registers, flags and pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= ALU_ADD;
            pc      <= '0;
            zf      <= 1'b0;
            nf      <= 1'b0;
`ifdef ALU_CTRL_OVF_TRAP_EN
            ovf     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                instr_q <= instr;
                if (is_alu_in) begin
                    alu_a  <= rs_data;
                    alu_b  <= (opc_in == OPC_ADDI) ? imm7_ext : rt_data;
                    alu_op <= opc_to_aluop(opc_in);
                end
            end
            if (state == ST_WB) begin
                zf <= alu_z;
                nf <= alu_n;
                pc <= pc_inc;
`ifdef ALU_CTRL_OVF_TRAP_EN
                if (ovf_now) begin
                    ovf <= 1'b1;
                end
`endif
            end
            if (state == ST_BRANCH) begin
                pc <= br_taken ? (pc_inc + br_off) : pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table, hand-written corner sequences, random run against an ISA-level model.
// Latency: checks accept-to-ready latency of every instruction.
// Backpressure: exercises instr_valid held outside IDLE.
module tb_alu_issue_ctrl;

    logic        clk, rst, instr_valid, instr_ready, halted, alu_z, alu_n;
    logic [15:0] instr, alu_a, alu_b, alu_result, dbg_data;
    logic [1:0]  alu_op;
    logic [7:0]  pc;
    logic [2:0]  dbg_addr;
`ifdef ALU_CTRL_OVF_TRAP_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .pc(pc),
        .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_CTRL_OVF_TRAP_EN
        , .ovf(ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: registers result and flags every cycle
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_result <= alu_f(alu_a, alu_b, alu_op);
        alu_z      <= (alu_f(alu_a, alu_b, alu_op) == 16'h0000);
        alu_n      <= alu_f(alu_a, alu_b, alu_op) >> 15 != 16'h0;
    end

    // ---------------- ISA-level reference model ----------------
    logic [15:0] m_regs [8];
    logic [7:0]  m_pc;
    logic        m_zf, m_nf, m_halt, m_ovf;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_pc = 8'h0; m_zf = 1'b0; m_nf = 1'b0; m_halt = 1'b0; m_ovf = 1'b0;
    endfunction

    // Executes one word; returns expected accept-to-ready cycles (0 = never ready again)
    function automatic int model_exec(input logic [15:0] w);
        int opc, rd, rs, rt, sa, sb, full, off;
        logic [15:0] res;
        logic ovf_hit, taken;
        opc = int'(w[15:13]); rd = int'(w[12:10]); rs = int'(w[9:7]); rt = int'(w[6:4]);
        if (opc <= 4) begin
            sa = int'($signed(m_regs[rs]));
            sb = (opc == 4) ? int'($signed(w[6:0])) : int'($signed(m_regs[rt]));
            case (opc)
                1:       full = sa - sb;
                2:       full = int'(m_regs[rs] & m_regs[rt]);
                3:       full = int'(m_regs[rs] | m_regs[rt]);
                default: full = sa + sb;
            endcase
            res     = full[15:0];
            ovf_hit = (opc == 0 || opc == 1 || opc == 4) && (full > 32767 || full < -32768);
            m_zf = (res == 16'h0);
            m_nf = res[15];
            if (rd != 0) m_regs[rd] = res;
            m_pc = m_pc + 8'd1;
`ifdef ALU_CTRL_OVF_TRAP_EN
            if (ovf_hit) begin
                m_ovf = 1'b1; m_halt = 1'b1;
                return 0;
            end
`else
            if (ovf_hit) m_ovf = 1'b0;
`endif
            return 3;
        end else if (opc < 7) begin
            taken = (opc == 5) ? m_zf : m_nf;
            off   = taken ? int'($signed(w[9:0])) : 0;
            m_pc  = 8'(int'(m_pc) + 1 + off);
            return 2;
        end
        m_halt = 1'b1;
        return 0;
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [15:0] fn_r(input logic [2:0] opc, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        return {opc, rd, rs, rt, 4'b0000};
    endfunction
    function automatic logic [15:0] fn_i(input logic [2:0] rd, input logic [2:0] rs, input logic [6:0] imm);
        return {3'b100, rd, rs, imm};
    endfunction
    function automatic logic [15:0] fn_b(input logic [2:0] opc, input logic [9:0] imm);
        return {opc, 3'b000, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_reg(input string nm, input int idx, input logic [15:0] exp);
        dbg_addr = 3'(idx);
        #1;
        chk(nm, 32'(dbg_data), 32'(exp));
    endtask

    // Presents a word at a negedge, counts negedges until ready returns (bounded)
    task automatic issue(input logic [15:0] w, input int maxc, output int lat, output logic [1:0] op_seen);
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = 16'h0;
        lat = 0; op_seen = 2'bxx;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (k == 1) op_seen = alu_op;
            if (instr_ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string nm, input logic [15:0] w);
        int lat, exp_lat;
        logic [1:0] op;
        exp_lat = model_exec(w);
        issue(w, 6, lat, op);
        chk($sformatf("%s_lat", nm), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s_pc", nm), 32'(pc), 32'(m_pc));
        chk($sformatf("%s_halted", nm), 32'(halted), 32'(m_halt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] w;
        int          lat;
        logic [2:0]  rsel;
        logic [15:0] rval;
        logic [7:0]  pc;
        logic        chk_op;
        logic [1:0]  op;
    } vec_t;

    vec_t tbl [22];

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [1:0] op;
        logic [15:0] w;

        tbl[0]  = '{fn_i(3'd1, 3'd0, 7'd5),          3, 3'd1, 16'h0005, 8'h01, 1'b1, 2'b00};
        tbl[1]  = '{fn_i(3'd2, 3'd0, 7'h7D),         3, 3'd2, 16'hFFFD, 8'h02, 1'b1, 2'b00};
        tbl[2]  = '{fn_r(3'b000, 3'd3, 3'd1, 3'd2),  3, 3'd3, 16'h0002, 8'h03, 1'b1, 2'b00};
        tbl[3]  = '{fn_r(3'b001, 3'd4, 3'd1, 3'd1),  3, 3'd4, 16'h0000, 8'h04, 1'b1, 2'b01};
        tbl[4]  = '{fn_b(3'b101, 10'd4),             2, 3'd4, 16'h0000, 8'h09, 1'b0, 2'b00};
        tbl[5]  = '{fn_r(3'b001, 3'd5, 3'd0, 3'd1),  3, 3'd5, 16'hFFFB, 8'h0A, 1'b1, 2'b01};
        tbl[6]  = '{fn_b(3'b110, 10'h3FE),           2, 3'd5, 16'hFFFB, 8'h09, 1'b0, 2'b00};
        tbl[7]  = '{fn_b(3'b101, 10'd5),             2, 3'd5, 16'hFFFB, 8'h0A, 1'b0, 2'b00};
        tbl[8]  = '{fn_i(3'd1, 3'd0, 7'd60),         3, 3'd1, 16'h003C, 8'h0B, 1'b1, 2'b00};
        tbl[9]  = '{fn_r(3'b000, 3'd1, 3'd1, 3'd1),  3, 3'd1, 16'h0078, 8'h0C, 1'b1, 2'b00};
        tbl[10] = '{fn_r(3'b000, 3'd1, 3'd1, 3'd1),  3, 3'd1, 16'h00F0, 8'h0D, 1'b1, 2'b00};
        tbl[11] = '{fn_r(3'b000, 3'd2, 3'd1, 3'd1),  3, 3'd2, 16'h01E0, 8'h0E, 1'b1, 2'b00};
        tbl[12] = '{fn_r(3'b000, 3'd2, 3'd2, 3'd2),  3, 3'd2, 16'h03C0, 8'h0F, 1'b1, 2'b00};
        tbl[13] = '{fn_r(3'b000, 3'd2, 3'd2, 3'd2),  3, 3'd2, 16'h0780, 8'h10, 1'b1, 2'b00};
        tbl[14] = '{fn_r(3'b000, 3'd2, 3'd2, 3'd2),  3, 3'd2, 16'h0F00, 8'h11, 1'b1, 2'b00};
        tbl[15] = '{fn_r(3'b011, 3'd2, 3'd2, 3'd1),  3, 3'd2, 16'h0FF0, 8'h12, 1'b1, 2'b11};
        tbl[16] = '{fn_r(3'b010, 3'd3, 3'd1, 3'd2),  3, 3'd3, 16'h00F0, 8'h13, 1'b1, 2'b10};
        tbl[17] = '{fn_r(3'b011, 3'd7, 3'd1, 3'd2),  3, 3'd7, 16'h0FF0, 8'h14, 1'b1, 2'b11};
        tbl[18] = '{fn_r(3'b000, 3'd0, 3'd1, 3'd1),  3, 3'd0, 16'h0000, 8'h15, 1'b1, 2'b00};
        tbl[19] = '{fn_b(3'b110, 10'd3),             2, 3'd0, 16'h0000, 8'h16, 1'b0, 2'b00};
        tbl[20] = '{fn_r(3'b001, 3'd0, 3'd1, 3'd1),  3, 3'd0, 16'h0000, 8'h17, 1'b1, 2'b01};
        tbl[21] = '{fn_b(3'b101, 10'd8),             2, 3'd0, 16'h0000, 8'h20, 1'b0, 2'b00};

        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; dbg_addr = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
`ifdef ALU_CTRL_OVF_TRAP_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        for (int i = 0; i < 8; i++) check_reg($sformatf("rst_r%0d", i), i, 16'h0);

        // Directed vector table
        for (int i = 0; i < 22; i++) begin
            void'(model_exec(tbl[i].w));
            issue(tbl[i].w, 6, lat, op);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
            if (tbl[i].chk_op) chk($sformatf("vec%0d_op", i), 32'(op), 32'(tbl[i].op));
            check_reg($sformatf("vec%0d_reg", i), int'(tbl[i].rsel), tbl[i].rval);
        end

        // instr_valid held through EXEC/WB: second word waits for IDLE, consumed once
        @(negedge clk);
        instr = fn_r(3'b000, 3'd6, 3'd1, 3'd1); instr_valid = 1'b1;
        void'(model_exec(instr));
        @(posedge clk); #1;
        instr = fn_i(3'd6, 3'd6, 7'd1);
        @(negedge clk); chk("hold_exec_ready", 32'(instr_ready), 32'd0);
        @(negedge clk); chk("hold_wb_ready", 32'(instr_ready), 32'd0);
        @(negedge clk); chk("hold_idle_ready", 32'(instr_ready), 32'd1);
        chk("hold_idle_pc", 32'(pc), 32'h21);
        void'(model_exec(instr));
        @(posedge clk); #1;
        instr_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (instr_ready) begin lat = k; break; end
        end
        chk("hold_second_lat", 32'(lat), 32'd3);
        chk("hold_pc", 32'(pc), 32'(m_pc));
        check_reg("hold_r6", 6, m_regs[6]);

        // Reset asserted during WB abandons the write
        @(negedge clk);
        instr = fn_r(3'b000, 3'd6, 3'd1, 3'd1); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwb_ready", 32'(instr_ready), 32'd1);
        chk("rstwb_pc", 32'(pc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reg("rstwb_r6", 6, 16'h0);
        check_reg("rstwb_r1", 1, 16'h0);
        chk("rstwb_ready_after", 32'(instr_ready), 32'd1);

        // Branch before any ALU op is not taken
        run_and_check("coldbz", fn_b(3'b101, 10'd20));

        // HALT: ready stays low, pc frozen, further words ignored
        run_and_check("pre_halt", fn_i(3'd1, 3'd0, 7'd7));
        run_and_check("halt", {3'b111, 13'h0});
        chk("halt_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        instr = fn_i(3'd2, 3'd0, 7'd1); instr_valid = 1'b1;
        repeat (4) @(negedge clk);
        instr_valid = 1'b0;
        chk("halt_frozen_pc", 32'(pc), 32'd2);
        chk("halt_still", 32'(halted), 32'd1);
        check_reg("halt_r2", 2, 16'h0);
        do_reset();
        chk("halt_cleared", 32'(halted), 32'd0);

        // Build r1 = 0x7FFF without overflow, then ADDI r2,r1,1
        run_and_check("ov_seed", fn_i(3'd1, 3'd0, 7'd1));
        for (int i = 0; i < 14; i++) begin
            run_and_check($sformatf("ov_dbl%0d", i), fn_r(3'b000, 3'd1, 3'd1, 3'd1));
            run_and_check($sformatf("ov_inc%0d", i), fn_i(3'd1, 3'd1, 7'd1));
        end
        check_reg("ov_r1", 1, 16'h7FFF);
        run_and_check("ov_addi", fn_i(3'd2, 3'd1, 7'd1));
        check_reg("ov_r2", 2, 16'h8000);
`ifdef ALU_CTRL_OVF_TRAP_EN
        chk("ov_flag", 32'(ovf), 32'd1);
        chk("ov_halted", 32'(halted), 32'd1);
`else
        chk("ov_halted", 32'(halted), 32'd0);
        run_and_check("ov_continue", fn_i(3'd3, 3'd0, 7'd1));
        check_reg("ov_r3", 3, 16'h0001);
`endif
        do_reset();

        // Random instruction stream against the model
        for (int i = 0; i < 300; i++) begin
            w = {3'($urandom_range(0, 6)), 13'($urandom)};
            run_and_check($sformatf("rnd%0d", i), w);
            if (w[15:13] <= 3'd4) check_reg($sformatf("rnd%0d_rd", i), int'(w[12:10]), m_regs[w[12:10]]);
`ifdef ALU_CTRL_OVF_TRAP_EN
            chk($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(m_ovf));
`endif
            if ((i % 50) == 49) begin
                for (int r = 0; r < 8; r++) check_reg($sformatf("rnd%0d_r%0d", i, r), r, m_regs[r]);
            end
            if (m_halt) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
